ivector_rr_fifo: RTL and testbench
==================================

// Module: ivector_rr_fifo
// PURPOSE
//  Parametrised multi-channel indication vector. say(meth,v) enqueues v into
//  per-channel FIFO[meth]; a round-robin arbiter drains non-empty channels onto
//  one ind$heard(meth,v) indication port. Supersedes fixed 10-channel vector:
//  parametrised channel count/depth/width, per-channel backpressure, fair output.
// PARAMETERS
//  CHANNELS    10   number of channels (>=2)
//  DEPTH       4    entries per channel FIFO (power of 2, >=2)
//  DATA_WIDTH  32   payload width of v
//  IDX_WIDTH   32   width of meth fields
// PORTS
//  CLK                   in   1                      clock, all state on posedge
//  RST                   in   1                      synchronous reset, active-high
//  say__ENA              in   1                      enqueue request
//  say_meth              in   IDX_WIDTH              target channel
//  say_v                 in   DATA_WIDTH             payload
//  say__RDY              out  1                      FIFO[say_meth] can accept
//  ind$heard__ENA        out  1                      indication fires this cycle
//  ind$heard_heard_meth  out  IDX_WIDTH              granted channel index
//  ind$heard_heard_v     out  DATA_WIDTH             head entry of granted channel
//  ind$heard__RDY        in   1                      downstream can take indication
//  nonempty              out  CHANNELS               bit c = FIFO[c] holds >=1 entry
// BEHAVIOUR
//  - Reset (RST high at posedge): all FIFOs empty, rd/wr ptrs 0, counts 0,
//    last_grant = CHANNELS-1. Outputs then: say__RDY=1 if say_meth<CHANNELS,
//    ind$heard__ENA=0, nonempty=0, heard_meth=0, heard_v=0. RST wins over
//    same-cycle enq/deq; in-flight data discarded.
//  - say__RDY = (say_meth < CHANNELS) && count[say_meth] < DEPTH. Comb. from
//    say_meth and state only; never depends on say__ENA or ind$heard__RDY.
//  - Enqueue occurs iff say__ENA && say__RDY; say__ENA while !say__RDY is
//    ignored (no state change). Out-of-range say_meth: RDY=0, never stored.
//  - Full channel refuses even if same channel dequeues this cycle (no bypass).
//  - Enqueue-to-visible latency 1 cycle: entry written at edge N may be
//    indicated in cycle N+1 at earliest. No comb. path say_* -> ind$heard_*.
//  - Arbiter (comb.): search c = last_grant+1 .. last_grant+CHANNELS mod
//    CHANNELS; first c with count[c]!=0 is grant. None -> no grant.
//  - ind$heard__ENA = grant_valid && ind$heard__RDY. heard_meth = grant index
//    zero-extended; heard_v = FIFO[grant] head. When ENA=0, meth/v = 0.
//  - On ENA: pop grant FIFO (rd_ptr+1 wrap mod DEPTH, count-1); last_grant<=grant.
//    Without ENA last_grant holds (no pointer advance while blocked).
//  - Same cycle enq+deq on same non-full channel: count unchanged, both ptrs move.
//  - At most one enqueue and one dequeue per cycle total.
//  - Counts are $clog2(DEPTH+1) bits; never exceed DEPTH, never underflow.
//  - Per-channel order is FIFO; cross-channel order is arbitration order only.
//  - ind$heard__RDY low: all FIFOs retain data; say may keep filling until full.
// TESTING
//  1 Reset: RST=1 2 cycles with say__ENA=1 -> nonempty=0, ind$heard__ENA=0,
//    no entry stored after RST falls.
//  2 Latency: say(3,0xA5) at edge N, ind$heard__RDY=1 -> cycle N+1
//    heard__ENA=1, meth=3, v=0xA5; cycle N+2 nonempty=0.
//  3 Full/backpressure: heard__RDY=0, say(2,k) k=1..5, DEPTH=4 -> say__RDY=0
//    on 5th, 5th dropped; release RDY -> 1,2,3,4 on channel 2 in order.
//  4 Round-robin: hold RDY=0, load ch0,ch1,ch9 with 2 entries each, then RDY=1
//    -> meth sequence 0,1,9,0,1,9.
//  5 Simultaneous: ch5 has 3 entries, say(5,x) same cycle as ch5 pop -> count
//    stays 3, x emerges after the original two remaining entries.
//  6 Range/reset mid-op: say(CHANNELS,..) -> say__RDY=0, nothing stored;
//    RST pulse with ch4 half full -> nonempty=0, next say(4,7) indicated 7.

Source files
------------

// File: rtl/ivector_rr_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : ivector_rr_fifo_if
//  Purpose  : say / ind_heard handshake bundle for the round-robin vector FIFO
//  Revision : 1.0
// ============================================================================
interface ivector_rr_fifo_if #(
  parameter int CHANNELS   = 10,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 32
);
  logic                  say__ENA;
  logic [IDX_WIDTH-1:0]  say_meth;
  logic [DATA_WIDTH-1:0] say_v;
  logic                  say__RDY;
  logic                  ind_heard__ENA;
  logic [IDX_WIDTH-1:0]  ind_heard_heard_meth;
  logic [DATA_WIDTH-1:0] ind_heard_heard_v;
  logic                  ind_heard__RDY;
  logic [CHANNELS-1:0]   nonempty;

  modport master (
    output say__ENA, say_meth, say_v, ind_heard__RDY,
    input  say__RDY, ind_heard__ENA, ind_heard_heard_meth, ind_heard_heard_v, nonempty
  );

  modport slave (
    input  say__ENA, say_meth, say_v, ind_heard__RDY,
    output say__RDY, ind_heard__ENA, ind_heard_heard_meth, ind_heard_heard_v, nonempty
  );
endinterface
`default_nettype wire

// File: rtl/ivector_rr_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ivector_rr_fifo
//  Purpose  : per-channel FIFOs drained onto one indication port by round robin
//  Revision : 1.0
// ============================================================================
module ivector_rr_fifo #(
  parameter int CHANNELS   = 10,
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 32
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  ivector_rr_fifo_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int GW = $clog2(CHANNELS);

  logic [DATA_WIDTH-1:0] r_mem     [CHANNELS][DEPTH];
  logic [PW-1:0]         r_rd_ptr  [CHANNELS];
  logic [PW-1:0]         r_wr_ptr  [CHANNELS];
  logic [CW-1:0]         r_count   [CHANNELS];
  logic [GW-1:0]         r_last_grant;

  logic                  w_in_range;
  logic [GW-1:0]         w_say_ch;
  logic                  w_say_rdy;
  logic                  w_enq;
  logic                  w_grant_valid;
  logic [GW-1:0]         w_grant;
  logic                  w_deq;
  logic                  w_push [CHANNELS];
  logic                  w_pop  [CHANNELS];

  // Full-width decode so out-of-range indices (any upper bits set) never alias.
  always_comb begin
    w_in_range = 1'b0;
    w_say_ch   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.say_meth == IDX_WIDTH'(c)) begin
        w_in_range = 1'b1;
        w_say_ch   = GW'(c);
      end
    end
  end

  assign w_say_rdy = w_in_range && (r_count[w_say_ch] < CW'(DEPTH));
  assign w_enq     = bus.say__ENA && w_say_rdy;

  // Search starts one past the last winner so every channel gets a turn.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      if (!w_grant_valid && (r_count[(int'(r_last_grant) + i) % CHANNELS] != '0)) begin
        w_grant_valid = 1'b1;
        w_grant       = GW'((int'(r_last_grant) + i) % CHANNELS);
      end
    end
  end

  assign w_deq = w_grant_valid && bus.ind_heard__RDY;

  assign bus.say__RDY             = w_say_rdy;
  assign bus.ind_heard__ENA       = w_deq;
  assign bus.ind_heard_heard_meth = w_deq ? IDX_WIDTH'(w_grant) : '0;
  assign bus.ind_heard_heard_v    = w_deq ? r_mem[w_grant][r_rd_ptr[w_grant]] : '0;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      assign w_push[c]       = w_enq && (w_say_ch == GW'(c));
      assign w_pop[c]        = w_deq && (w_grant == GW'(c));
      assign bus.nonempty[c] = (r_count[c] != '0);
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_rd_ptr[c] <= '0;
        r_wr_ptr[c] <= '0;
        r_count[c]  <= '0;
      end
      r_last_grant <= GW'(CHANNELS - 1);
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_push[c]) begin
          r_wr_ptr[c] <= r_wr_ptr[c] + PW'(1);
        end
        if (w_pop[c]) begin
          r_rd_ptr[c] <= r_rd_ptr[c] + PW'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({w_push[c], w_pop[c]})
          2'b10:   r_count[c] <= r_count[c] + CW'(1);
          2'b01:   r_count[c] <= r_count[c] - CW'(1);
          default: r_count[c] <= r_count[c];
        endcase
      end
      if (w_deq) begin
        r_last_grant <= w_grant;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && w_enq) begin
      r_mem[w_say_ch][r_wr_ptr[w_say_ch]] <= bus.say_v;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ivector_rr_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ivector_rr_fifo
//  Purpose  : queue-model and directed-vector bench for ivector_rr_fifo
//  Revision : 1.0
// ============================================================================
module tb_ivector_rr_fifo;
  localparam int CH = 10;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ivector_rr_fifo_if #(.CHANNELS(CH), .DATA_WIDTH(32), .IDX_WIDTH(32)) bus ();

  ivector_rr_fifo #(.CHANNELS(CH), .DEPTH(DP), .DATA_WIDTH(32), .IDX_WIDTH(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per channel plus the last granted index.
  logic [31:0] mq [CH][$];
  int          m_lg = CH - 1;
  bit          armed = 1'b0;
  int          heard_log [$];

  bit          e_rdy, e_ena, found;
  int          g;
  logic [31:0] e_meth, e_v;
  logic [CH-1:0] e_ne;

  always @(negedge clk) begin
    if (armed) begin
      e_rdy = 1'b0;
      if (bus.say_meth < CH) e_rdy = (mq[bus.say_meth].size() < DP);
      found = 1'b0;
      g     = 0;
      for (int i = 1; i <= CH; i++) begin
        if (!found && mq[(m_lg + i) % CH].size() != 0) begin
          found = 1'b1;
          g     = (m_lg + i) % CH;
        end
      end
      e_ena  = found && bus.ind_heard__RDY;
      e_meth = e_ena ? 32'(g) : 32'd0;
      e_v    = e_ena ? mq[g][0] : 32'd0;
      for (int c = 0; c < CH; c++) e_ne[c] = (mq[c].size() != 0);
      check("mdl_say_rdy", 64'(bus.say__RDY), 64'(e_rdy));
      check("mdl_heard_ena", 64'(bus.ind_heard__ENA), 64'(e_ena));
      check("mdl_heard_meth", 64'(bus.ind_heard_heard_meth), 64'(e_meth));
      check("mdl_heard_v", 64'(bus.ind_heard_heard_v), 64'(e_v));
      check("mdl_nonempty", 64'(bus.nonempty), 64'(e_ne));
      if (e_ena) heard_log.push_back(g);
    end
    if (rst) begin
      for (int c = 0; c < CH; c++) mq[c].delete();
      m_lg  = CH - 1;
      armed = 1'b1;
    end else if (armed) begin
      if (e_ena) begin
        void'(mq[g].pop_front());
        m_lg = g;
      end
      if (bus.say__ENA && e_rdy) mq[bus.say_meth].push_back(bus.say_v);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic say(input int meth, input logic [31:0] v);
    bus.say__ENA = 1'b1;
    bus.say_meth = 32'(meth);
    bus.say_v    = v;
    cyc();
    bus.say__ENA = 1'b0;
  endtask

  int exp_seq [6];

  initial begin
    exp_seq = '{0, 1, 9, 0, 1, 9};
    bus.say__ENA       = 1'b1;
    bus.say_meth       = 32'd0;
    bus.say_v          = 32'h1;
    bus.ind_heard__RDY = 1'b1;

    // 1: reset with enqueue requests asserted
    cyc();
    cyc();
    check("rst_nonempty", 64'(bus.nonempty), 64'd0);
    check("rst_heard_ena", 64'(bus.ind_heard__ENA), 64'd0);
    rst          = 1'b0;
    bus.say__ENA = 1'b0;
    cyc();
    check("rst_no_store", 64'(bus.nonempty), 64'd0);
    check("rst_say_rdy", 64'(bus.say__RDY), 64'd1);

    // 2: one-cycle latency
    say(3, 32'hA5);
    check("lat_ena", 64'(bus.ind_heard__ENA), 64'd1);
    check("lat_meth", 64'(bus.ind_heard_heard_meth), 64'd3);
    check("lat_v", 64'(bus.ind_heard_heard_v), 64'hA5);
    cyc();
    check("lat_empty", 64'(bus.nonempty), 64'd0);

    // 3: fill channel 2 under backpressure
    bus.ind_heard__RDY = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      bus.say__ENA = 1'b1;
      bus.say_meth = 32'd2;
      bus.say_v    = 32'(k);
      #1;
      check("full_say_rdy", 64'(bus.say__RDY), (k <= 4) ? 64'd1 : 64'd0);
      cyc();
    end
    bus.say__ENA = 1'b0;
    check("full_ne", 64'(bus.nonempty), 64'h4);
    bus.ind_heard__RDY = 1'b1;
    #1;
    for (int k = 1; k <= 4; k++) begin
      check("full_order", 64'(bus.ind_heard_heard_v), 64'(k));
      cyc();
    end
    check("full_drained", 64'(bus.nonempty), 64'd0);

    // 4: round robin after a fresh reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.ind_heard__RDY = 1'b0;
    for (int r = 0; r < 2; r++) begin
      say(0, 32'(100 + r));
      say(1, 32'(110 + r));
      say(9, 32'(190 + r));
    end
    check("rr_ne", 64'(bus.nonempty), 64'h203);
    heard_log.delete();
    bus.ind_heard__RDY = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    check("rr_count", 64'(heard_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < heard_log.size(); i++)
      check("rr_seq", 64'(heard_log[i]), 64'(exp_seq[i]));

    // 5: enqueue and dequeue on the same channel in one cycle
    bus.ind_heard__RDY = 1'b0;
    say(5, 32'd51);
    say(5, 32'd52);
    say(5, 32'd53);
    bus.ind_heard__RDY = 1'b1;
    bus.say__ENA = 1'b1;
    bus.say_meth = 32'd5;
    bus.say_v    = 32'd54;
    #1;
    check("sim_rdy", 64'(bus.say__RDY), 64'd1);
    check("sim_v0", 64'(bus.ind_heard_heard_v), 64'd51);
    cyc();
    bus.say__ENA = 1'b0;
    for (int k = 52; k <= 54; k++) begin
      check("sim_v", 64'(bus.ind_heard_heard_v), 64'(k));
      cyc();
    end
    check("sim_empty", 64'(bus.nonempty), 64'd0);

    // 6: out-of-range index, then reset with data in flight
    bus.ind_heard__RDY = 1'b0;
    bus.say__ENA = 1'b1;
    bus.say_meth = 32'(CH);
    bus.say_v    = 32'hDEAD;
    #1;
    check("range_rdy", 64'(bus.say__RDY), 64'd0);
    cyc();
    bus.say_meth = 32'hFFFF_FFFF;
    #1;
    check("range_rdy_max", 64'(bus.say__RDY), 64'd0);
    cyc();
    bus.say__ENA = 1'b0;
    check("range_ne", 64'(bus.nonempty), 64'd0);
    say(4, 32'd1);
    say(4, 32'd2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_ne", 64'(bus.nonempty), 64'd0);
    say(4, 32'd7);
    bus.ind_heard__RDY = 1'b1;
    #1;
    check("mid_rst_ena", 64'(bus.ind_heard__ENA), 64'd1);
    check("mid_rst_meth", 64'(bus.ind_heard_heard_meth), 64'd4);
    check("mid_rst_v", 64'(bus.ind_heard_heard_v), 64'd7);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
